// File: rtl/people_counter_pkg.sv
// people_counter_pkg: shared SBqM occupancy width, saturation ceiling and debounce FSM states
// Contents:
//   CNT_W       - occupancy width; the waiting-time lookup memories reuse it
//   MAX_COUNT   - saturation ceiling, at most 2^CNT_W-1
//   deb_state_t - debounce FSM states {STABLE, CHANGING}
package sbqm_pkg;
    localparam int CNT_W     = 3;
    localparam int MAX_COUNT = 7;
    typedef enum logic {STABLE, CHANGING} deb_state_t;
endpackage

// File: rtl/people_counter_if.sv
// people_counter_if: sensor inputs and occupancy/flag outputs of the queue people counter
// Signals:
//   front_sensor, back_sensor - raw photocells, high = beam broken (master drives)
//   pcount, empty, full       - registered occupancy and flags (slave drives)
//   overflow_err, underflow_err - one-cycle illegal-event pulses (slave drives)
interface people_counter_if;
    import sbqm_pkg::*;
    logic             front_sensor;
    logic             back_sensor;
    logic [CNT_W-1:0] pcount;
    logic             empty;
    logic             full;
    logic             overflow_err;
    logic             underflow_err;
    modport master (output front_sensor, back_sensor,
                    input  pcount, empty, full, overflow_err, underflow_err);
    modport slave  (input  front_sensor, back_sensor,
                    output pcount, empty, full, overflow_err, underflow_err);
endinterface

// File: rtl/people_counter_sensor_conditioner.sv
// sensor_conditioner: synchronize, debounce and rising-edge-detect one raw photocell
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_raw      - raw asynchronous sensor level
//   o_pulse    - registered one-cycle pulse on each accepted 0->1 level change
module sensor_conditioner
    import sbqm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          r_sync1, r_sync2, r_stable, r_pulse;
    deb_state_t    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt, w_cur;
    logic          w_mis, w_flip;
    // r_cnt holds the number of mismatching samples already seen; the current
    // mismatch sample is the DEBOUNCE_CYCLES-th when r_cnt reaches DEBOUNCE_CYCLES-1
    always_comb begin
        w_mis   = r_sync2 != r_stable;
        w_cur   = (r_state == CHANGING) ? r_cnt : '0;
        w_flip  = w_mis && (w_cur == CW'(DEBOUNCE_CYCLES - 1));
        w_state = (w_mis && !w_flip) ? CHANGING : STABLE;
        w_cnt   = (w_mis && !w_flip) ? w_cur + CW'(1) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_stable <= r_stable ^ w_flip;
            r_pulse  <= w_flip & ~r_stable;
        end
    end
    assign o_pulse = r_pulse;
endmodule

// File: rtl/people_counter.sv
// people_counter: bank-queue occupancy counter fed by debounced entry/exit photocells
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - people_counter_if.slave: raw sensors in; pcount, empty, full,
//                overflow_err, underflow_err out (all registered)
module people_counter
    import sbqm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    people_counter_if.slave  bus
);
    logic             w_ent_p, w_ext_p;
    logic             w_inc, w_dec, w_ovf, w_udf;
    logic [CNT_W-1:0] r_pcount, w_next;
    logic             r_empty, r_full, r_ovf, r_udf;
    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front (
        .clk(clk), .rst_n(rst_n), .i_raw(bus.front_sensor), .o_pulse(w_ent_p)
    );
    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(clk), .rst_n(rst_n), .i_raw(bus.back_sensor), .o_pulse(w_ext_p)
    );
    // simultaneous entry and exit cancel out, so neither saturates nor errors
    always_comb begin
        w_inc  = w_ent_p && !w_ext_p && (r_pcount != CNT_W'(MAX_COUNT));
        w_ovf  = w_ent_p && !w_ext_p && (r_pcount == CNT_W'(MAX_COUNT));
        w_dec  = w_ext_p && !w_ent_p && (r_pcount != '0);
        w_udf  = w_ext_p && !w_ent_p && (r_pcount == '0);
        w_next = w_inc ? r_pcount + CNT_W'(1) : w_dec ? r_pcount - CNT_W'(1) : r_pcount;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcount <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_pcount <= w_next;
            r_empty  <= w_next == '0;
            r_full   <= w_next == CNT_W'(MAX_COUNT);
            r_ovf    <= w_ovf;
            r_udf    <= w_udf;
        end
    end
    assign bus.pcount        = r_pcount;
    assign bus.empty         = r_empty;
    assign bus.full          = r_full;
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_udf;
endmodule

// File: tb/tb_people_counter.sv
// tb_people_counter: directed table-driven checks of people_counter plus latency and reset sequences
module tb_people_counter;
    typedef struct {
        int f_len;
        int b_len;
        int exp_p;
        int exp_ovf;
        int exp_udf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ovf_cyc = 0;
    int   udf_cyc = 0;
    vec_t vecs[$];

    people_counter_if bus();

    people_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ovf_cyc <= ovf_cyc + int'(bus.overflow_err);
        udf_cyc <= udf_cyc + int'(bus.underflow_err);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int p);
        chk({tag, " pcount"}, int'(bus.pcount), p);
        chk({tag, " empty"}, int'(bus.empty), int'(p == 0));
        chk({tag, " full"}, int'(bus.full), int'(p == 7));
    endtask

    task automatic add(input int f, input int b, input int p, input int o, input int u);
        vec_t v;
        v.f_len = f; v.b_len = b; v.exp_p = p; v.exp_ovf = o; v.exp_udf = u;
        vecs.push_back(v);
    endtask

    // Holds each sensor high for the given number of clock edges, then lets both settle.
    task automatic apply(input int f, input int b);
        @(negedge clk);
        ovf_cyc = 0;
        udf_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            bus.front_sensor = (i < f);
            bus.back_sensor  = (i < b);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        // table starts from pcount=1 left by the latency sequence
        add(0, 10, 0, 0, 0);
        add(0, 10, 0, 0, 1);
        add(2, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(10, 0, i, 0, 0);
        add(10, 0, 7, 1, 0);
        add(10, 10, 7, 0, 0);
        for (int i = 6; i >= 3; i--) add(0, 10, i, 0, 0);
        add(10, 10, 3, 0, 0);
        add(0, 3, 3, 0, 0);
        add(4, 0, 4, 0, 0);
        add(10, 0, 5, 0, 0);

        repeat (3) @(negedge clk);
        chk_state("reset", 0);
        chk("reset ovf", int'(bus.overflow_err), 0);
        chk("reset udf", int'(bus.underflow_err), 0);
        rst_n = 1'b1;

        // latency: raw rise counts on exactly the 7th edge, held beam counts once
        @(negedge clk);
        bus.front_sensor = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) chk_state("lat edge6", 0);
            if (k == 7) chk_state("lat edge7", 1);
        end
        repeat (20) @(negedge clk);
        chk_state("lat held", 1);
        bus.front_sensor = 1'b0;
        repeat (20) @(negedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].f_len, vecs[i].b_len);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_p);
            chk($sformatf("vec%0d ovf cycles", i), ovf_cyc, vecs[i].exp_ovf);
            chk($sformatf("vec%0d udf cycles", i), udf_cyc, vecs[i].exp_udf);
        end

        // asynchronous reset mid-debounce at pcount=5, then held sensor re-counts
        @(negedge clk);
        bus.front_sensor = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async rst", 0);
        chk("async rst ovf", int'(bus.overflow_err), 0);
        chk("async rst udf", int'(bus.underflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) chk_state("post rst edge6", 0);
            if (k == 7) chk_state("post rst edge7", 1);
        end
        bus.front_sensor = 1'b0;
        repeat (20) @(negedge clk);
        chk_state("post rst settle", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
